// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer (byte lanes, req/gnt/rvalid handshake, load align/extend).
// Define LSU_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with a bus error.
module lsu_ctrl #(
  parameter int XLEN = 64
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wr_i,
  input  logic [1:0]      req_byte_i,
  input  logic            req_zero_extnd_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [7:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_err_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_misalign_o,
  output logic            resp_err_o,
  output logic            stall_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d, zx_q, zx_d, err_q, err_d, mis_q, mis_d;
  logic [1:0]      size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic            misalign, timeout;
  logic [7:0]      be_base;
  logic [XLEN-1:0] shifted, ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT so it is already cleared on WAIT entry.
  assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign misalign = ((req_byte_i == 2'b01) & req_addr_i[0])
                  | ((req_byte_i == 2'b10) & (|req_addr_i[1:0]))
                  | ((req_byte_i == 2'b11) & (|req_addr_i[2:0]));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    zx_d    = zx_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        wr_d    = req_wr_i;
        zx_d    = req_zero_extnd_i;
        size_d  = req_byte_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        rdata_d = '0;
        err_d   = 1'b0;
        mis_d   = misalign;
        state_d = misalign ? RESP : REQ;
      end
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) begin
        rdata_d = mem_rdata_i;
        err_d   = mem_err_i;
        state_d = RESP;
      end else if (timeout) begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      zx_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      zx_q    <= zx_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  end

  // Memory-side outputs are only driven while the request is presented.
  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = mem_req_o ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_we_o    = mem_req_o & wr_q;
  assign mem_be_o    = mem_req_o ? (be_base << addr_q[2:0]) : 8'h00;
  assign mem_wdata_o = mem_req_o ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;

  assign shifted = rdata_q >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ext = {{(XLEN-8){~zx_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{(XLEN-16){~zx_q & shifted[15]}}, shifted[15:0]};
      2'b10:   ext = {{(XLEN-32){~zx_q & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign req_ready_o     = (state_q == IDLE);
  assign resp_valid_o    = (state_q == RESP);
  assign resp_misalign_o = resp_valid_o & mis_q;
  assign resp_err_o      = resp_valid_o & err_q;
  assign resp_rdata_o    = (resp_valid_o & ~wr_q & ~err_q & ~mis_q) ? ext : '0;
  assign stall_o         = ((state_q == IDLE) & req_valid_i) | (state_q == REQ) | (state_q == WAIT);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: random loads/stores against a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        req_valid_i, req_ready_o, req_wr_i, req_zero_extnd_i;
  logic [1:0]  req_byte_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  mem_be_o;
  logic        resp_valid_o, resp_misalign_o, resp_err_o, stall_o;
  logic [63:0] resp_rdata_o;

  localparam int TO = 4;

`ifdef LSU_TIMEOUT_EN
  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
`else
  lsu_ctrl dut (
`endif
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_byte_i(req_byte_i), .req_zero_extnd_i(req_zero_extnd_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_misalign_o(resp_misalign_o), .resp_err_o(resp_err_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr; logic [1:0] sz; logic zx;
    logic [63:0] addr, wdata, rdata;
    logic err; int g, r;
  } txn_t;
  typedef struct { logic mis, err; logic [63:0] rdata; int cyc; } exp_t;

  txn_t memq[$];
  exp_t expq[$];
  exp_t mon_e;
  int   ncmp = 0, nfail = 0, cyc = 0;
  bit   manual = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_mis(logic [63:0] a, logic [1:0] sz);
    return (int'(a[2:0]) % nbytes(sz)) != 0;
  endfunction

  // Reference load: gather the addressed bytes one by one, then extend.
  function automatic logic [63:0] load_val(logic [63:0] d, logic [63:0] a, logic [1:0] sz, logic zx);
    int nb = nbytes(sz);
    int off = int'(a[2:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (!zx && nb < 8 && v[8*nb-1]) for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic txn_t mk(bit wr, logic [1:0] sz, bit zx, logic [63:0] a, logic [63:0] wd,
                              logic [63:0] rd, bit err, int g, int r);
    txn_t t;
    t.wr = wr; t.sz = sz; t.zx = zx; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.err = err; t.g = g; t.r = r;
    return t;
  endfunction

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  endtask

  task automatic issue(input txn_t t, input bit auto_mode, output int k);
    exp_t e;
    bit mis;
    mis = is_mis(t.addr, t.sz);
    req_wr_i = t.wr; req_byte_i = t.sz; req_zero_extnd_i = t.zx;
    req_addr_i = t.addr; req_wdata_i = t.wdata; req_valid_i = 1'b1;
    for (int n = 0; n < 300 && !req_ready_o; n++) @(negedge clk);
    chk("accept_wait", req_ready_o, 1);
    if (!req_ready_o) finish_now();
    #1 chk("stall_on_accept", stall_o, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    k = cyc;
    e.mis = mis;
    e.err = !mis && t.err;
    e.rdata = (mis || t.wr || t.err) ? 64'd0 : load_val(t.rdata, t.addr, t.sz, t.zx);
    e.cyc = mis ? k : k + 2 + t.g + t.r;
    if (auto_mode) begin
      expq.push_back(e);
      if (!mis) memq.push_back(t);
    end
  endtask

  task automatic serve(input txn_t t);
    int off = int'(t.addr[2:0]);
    int nb = nbytes(t.sz);
    int w = 0;
    logic [7:0] be = '0;
    for (int i = 0; i < nb; i++) be[off+i] = 1'b1;
    chk("mem_addr", mem_addr_o, {t.addr[63:3], 3'b000});
    chk("mem_we", mem_we_o, t.wr);
    chk("mem_be", mem_be_o, be);
    if (t.wr) for (int i = 0; i < nb; i++) chk("mem_wdata_lane", mem_wdata_o[8*(off+i) +: 8], t.wdata[8*i +: 8]);
    chk("ready_while_busy", req_ready_o, 0);
    forever begin
      mem_gnt_i = (w == t.g);
      // Stray rvalid with junk data while still in REQ must be ignored.
      mem_rvalid_i = (w != t.g) && ($urandom_range(0, 1) == 1);
      mem_rdata_i = {$urandom, $urandom};
      mem_err_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (w == t.g) break;
      w++;
      @(negedge clk);
      chk("mem_req_held", mem_req_o, 1);
      chk("mem_be_held", mem_be_o, be);
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    repeat (t.r + 1) @(negedge clk);
    chk("mem_req_dropped", mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = t.rdata; mem_err_i = t.err;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
  endtask

  initial begin
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    forever begin
      @(negedge clk);
      if (resetn && !manual && mem_req_o) begin
        if (memq.size() == 0) chk("unexpected_mem_req", mem_req_o, 0);
        else serve(memq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && resp_valid_o) begin
      if (expq.size() == 0) chk("unexpected_resp", resp_valid_o, 0);
      else begin
        mon_e = expq.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("resp_misalign", resp_misalign_o, mon_e.mis);
        chk("resp_err", resp_err_o, mon_e.err);
        chk("resp_rdata", resp_rdata_o, mon_e.rdata);
        chk("stall_in_resp", stall_o, 0);
        chk("ready_in_resp", req_ready_o, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    exp_t ex;
    int k;
    logic [2:0] m;
    req_valid_i = 0; req_wr_i = 0; req_byte_i = 0; req_zero_extnd_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_rdata", resp_rdata_o, 0);
    chk("rst_stall", stall_o, 0);
    resetn = 1'b1;
    @(negedge clk);

    issue(mk(0, 2'b00, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0), 1, k);
    issue(mk(0, 2'b10, 1, 64'h1004, 0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0), 1, k);
    issue(mk(1, 2'b01, 0, 64'h2002, 64'h1234, 0, 0, 3, 1), 1, k);
    issue(mk(0, 2'b10, 0, 64'h3002, 0, 64'h1111_2222_3333_4444, 0, 0, 0), 1, k);
    issue(mk(0, 2'b11, 0, 64'h4000, 0, 64'hFFFF_0000_FFFF_0000, 1, 1, 2), 1, k);
    issue(mk(0, 2'b01, 0, 64'h5006, 0, 64'h8001_0000_0000_0000, 0, 0, 0), 1, k);
    issue(mk(1, 2'b11, 0, 64'h6008, 64'h0123_4567_89AB_CDEF, 0, 0, 2, 0), 1, k);
    issue(mk(0, 2'b11, 0, 64'h7004, 0, 0, 0, 0, 0), 1, k);

    for (int n = 0; n < 300; n++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.sz = 2'($urandom_range(0, 3));
      t.zx = 1'($urandom_range(0, 1));
      t.addr = {$urandom, $urandom};
      m = 3'(nbytes(t.sz) - 1);
      if ($urandom_range(0, 3) != 0) t.addr[2:0] = t.addr[2:0] & ~m;
      t.wdata = {$urandom, $urandom};
      t.rdata = {$urandom, $urandom};
      t.err = ($urandom_range(0, 7) == 0);
      t.g = $urandom_range(0, 3);
      t.r = $urandom_range(0, 3);
      issue(t, 1, k);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int n = 0; n < 200 && (expq.size() != 0 || memq.size() != 0); n++) @(negedge clk);
    chk("drain_resp", 64'(expq.size()), 0);
    chk("drain_mem", 64'(memq.size()), 0);
    @(negedge clk);
    manual = 1;

`ifdef LSU_TIMEOUT_EN
    issue(mk(0, 2'b11, 0, 64'h8000, 0, 0, 0, 0, 0), 0, k);
    ex.mis = 0; ex.err = 1; ex.rdata = 0; ex.cyc = k + 1 + TO;
    expq.push_back(ex);
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b0;
    for (int n = 0; n < 20 && expq.size() != 0; n++) @(negedge clk);
    chk("timeout_resp_seen", 64'(expq.size()), 0);
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk); #1 mem_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
`endif

    issue(mk(0, 2'b11, 0, 64'h9000, 0, 0, 0, 0, 0), 0, k);
    @(negedge clk);
    chk("rst_test_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("stall_in_wait", stall_o, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_ready", req_ready_o, 1);
    chk("async_rst_mem_req", mem_req_o, 0);
    chk("async_rst_resp_valid", resp_valid_o, 0);
    chk("async_rst_stall", stall_o, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_CAFE_F00D;
    @(posedge clk); #1 mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("late_rvalid_ready", req_ready_o, 1);
    chk("late_rvalid_no_resp", resp_valid_o, 0);
    repeat (3) @(negedge clk);
    finish_now();
  end
endmodule
